// File: rtl/sync_pkg.sv
// Shared constants and helpers for the multi-channel synchroniser/debouncer.
package sync_pkg;

    localparam int SYNC_STAGES_DEF  = 2;
    localparam int DEBOUNCE_CNT_DEF = 1000;

    // Bounded loop so the function stays elaboration-friendly for any int argument.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_debounce_ch.sv
// One channel: synchroniser chain, stability counter, registered level and edge pulses.
module sync_debounce_ch
    import sync_pkg::*;
#(
    parameter int   SYNC_STAGES  = SYNC_STAGES_DEF,
    parameter int   DEBOUNCE_CNT = DEBOUNCE_CNT_DEF,
    parameter logic INIT_VAL     = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic signal_i,
    input  logic filter_en_i,
    output logic signal_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CNT_W = (clog2(DEBOUNCE_CNT) > 1) ? clog2(DEBOUNCE_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;

    logic             stable_s;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    assign stable_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {SYNC_STAGES{INIT_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], signal_i};
        end
    end

    // The counter only runs while the synchronised input disagrees with the output,
    // so any return to agreement restarts the stability window from zero.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (!filter_en_i) begin
            cnt_d   = '0;
            level_d = stable_s;
        end else if (stable_s == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = stable_s;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        rise_d = level_d & ~level_q;
        fall_d = ~level_d & level_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            level_q <= INIT_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign signal_o = level_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;

endmodule

// File: rtl/multi_sync_debounce.sv
// Multi-channel synchroniser and debouncer for asynchronous single-bit inputs.
module multi_sync_debounce
    import sync_pkg::*;
#(
    parameter int                CH_NUM       = 8,
    parameter int                SYNC_STAGES  = SYNC_STAGES_DEF,
    parameter int                DEBOUNCE_CNT = DEBOUNCE_CNT_DEF,
    parameter logic [CH_NUM-1:0] INIT_VAL     = '0
) (
    input  logic              i_sys_clk,
    input  logic              i_rst_n,
    input  logic [CH_NUM-1:0] i_signal,
    input  logic [CH_NUM-1:0] i_filter_en,
    output logic [CH_NUM-1:0] o_signal,
    output logic [CH_NUM-1:0] o_rise,
    output logic [CH_NUM-1:0] o_fall,
    output logic              o_changed
);

    for (genvar ch = 0; ch < CH_NUM; ch++) begin : g_ch
        sync_debounce_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE_CNT(DEBOUNCE_CNT),
            .INIT_VAL    (INIT_VAL[ch])
        ) u_ch (
            .clk_i      (i_sys_clk),
            .rst_ni     (i_rst_n),
            .signal_i   (i_signal[ch]),
            .filter_en_i(i_filter_en[ch]),
            .signal_o   (o_signal[ch]),
            .rise_o     (o_rise[ch]),
            .fall_o     (o_fall[ch])
        );
    end

    assign o_changed = |(o_rise | o_fall);

endmodule

// File: tb/tb_multi_sync_debounce.sv
// Directed bench for multi_sync_debounce: 4 channels, 2 sync stages, 5-cycle debounce.
module tb_multi_sync_debounce;

    localparam int CH = 4;

    logic          clk;
    logic          rstN;
    logic [CH-1:0] sigIn;
    logic [CH-1:0] filterEn;
    logic [CH-1:0] sigOut;
    logic [CH-1:0] riseOut;
    logic [CH-1:0] fallOut;
    logic          changedOut;

    int vectorCount = 0;
    int missCount   = 0;

    multi_sync_debounce #(
        .CH_NUM      (CH),
        .SYNC_STAGES (2),
        .DEBOUNCE_CNT(5),
        .INIT_VAL    (4'b0101)
    ) dut (
        .i_sys_clk  (clk),
        .i_rst_n    (rstN),
        .i_signal   (sigIn),
        .i_filter_en(filterEn),
        .o_signal   (sigOut),
        .o_rise     (riseOut),
        .o_fall     (fallOut),
        .o_changed  (changedOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [CH-1:0] expSig,
                            input logic [CH-1:0] expRise, input logic [CH-1:0] expFall);
        checkOutput({tag, "/sig"}, 32'(sigOut), 32'(expSig));
        checkOutput({tag, "/rise"}, 32'(riseOut), 32'(expRise));
        checkOutput({tag, "/fall"}, 32'(fallOut), 32'(expFall));
        checkOutput({tag, "/chg"}, 32'(changedOut), 32'(|(expRise | expFall)));
    endtask

    task automatic applyStimulus(input logic [CH-1:0] sig, input logic [CH-1:0] en);
        sigIn    = sig;
        filterEn = en;
    endtask

    // Advance n rising edges and land 1ns after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rstN = 1'b0;
        applyStimulus(4'b0101, 4'b1111);
        tick(3);
        checkAll("reset", 4'b0101, 4'b0000, 4'b0000);
        rstN = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            checkAll("postrst", 4'b0101, 4'b0000, 4'b0000);
        end

        // Filtered rise on ch1: update 7 edges after driving.
        applyStimulus(4'b0111, 4'b1111);
        tick(6);
        checkAll("frise_pre", 4'b0101, 4'b0000, 4'b0000);
        tick(1);
        checkAll("frise", 4'b0111, 4'b0010, 4'b0000);
        tick(1);
        checkAll("frise_post", 4'b0111, 4'b0000, 4'b0000);
        applyStimulus(4'b0101, 4'b1111);
        tick(7);
        checkAll("ffall", 4'b0101, 4'b0000, 4'b0010);

        // 4-cycle glitch on ch3 must be rejected.
        applyStimulus(4'b1101, 4'b1111);
        tick(4);
        applyStimulus(4'b0101, 4'b1111);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            checkAll("glitch", 4'b0101, 4'b0000, 4'b0000);
        end

        // 5-cycle pulse on ch3 is accepted, then the drop is accepted.
        applyStimulus(4'b1101, 4'b1111);
        tick(5);
        applyStimulus(4'b0101, 4'b1111);
        tick(1);
        checkAll("p5_pre", 4'b0101, 4'b0000, 4'b0000);
        tick(1);
        checkAll("p5_rise", 4'b1101, 4'b1000, 4'b0000);
        tick(4);
        checkAll("p5_hold", 4'b1101, 4'b0000, 4'b0000);
        tick(1);
        checkAll("p5_fall", 4'b0101, 4'b0000, 4'b1000);
        tick(1);
        checkAll("p5_done", 4'b0101, 4'b0000, 4'b0000);

        // Bypass on ch2 with a one-cycle low pulse.
        applyStimulus(4'b0101, 4'b1011);
        tick(2);
        applyStimulus(4'b0001, 4'b1011);
        tick(1);
        applyStimulus(4'b0101, 4'b1011);
        tick(1);
        checkAll("byp_lat", 4'b0101, 4'b0000, 4'b0000);
        tick(1);
        checkAll("byp_fall", 4'b0001, 4'b0000, 4'b0100);
        tick(1);
        checkAll("byp_rise", 4'b0101, 4'b0100, 4'b0000);
        tick(1);
        checkAll("byp_idle", 4'b0101, 4'b0000, 4'b0000);

        // Switch to bypass when ch2 count has reached 3.
        applyStimulus(4'b0101, 4'b1111);
        tick(2);
        applyStimulus(4'b0001, 4'b1111);
        tick(5);
        checkAll("mid_pre", 4'b0101, 4'b0000, 4'b0000);
        applyStimulus(4'b0001, 4'b1011);
        tick(1);
        checkAll("mid_byp", 4'b0001, 4'b0000, 4'b0100);
        applyStimulus(4'b0101, 4'b1111);
        tick(6);
        checkAll("mid_ref_pre", 4'b0001, 4'b0000, 4'b0000);
        tick(1);
        checkAll("mid_ref", 4'b0101, 4'b0100, 4'b0000);

        // All channels low, then all rise together.
        applyStimulus(4'b0000, 4'b1111);
        tick(7);
        checkAll("all_fall", 4'b0000, 4'b0000, 4'b0101);
        applyStimulus(4'b1111, 4'b1111);
        tick(7);
        checkAll("all_rise", 4'b1111, 4'b1111, 4'b0000);
        tick(1);

        // Reset while counts are pending, then a full re-filter.
        applyStimulus(4'b0000, 4'b1111);
        tick(4);
        rstN = 1'b0;
        #1;
        checkAll("rst_mid", 4'b0101, 4'b0000, 4'b0000);
        tick(2);
        rstN = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            checkAll("rst_refilt", 4'b0101, 4'b0000, 4'b0000);
        end
        tick(1);
        checkAll("rst_fall", 4'b0000, 4'b0000, 4'b0101);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
